// File: rtl/hbm_ieee1500_target_model.sv
// HBM IEEE1500 test-port target model.
// Oversamples the 1500 wrapper bus on clk. WIR = {channel[3:0], opcode[7:0]}.
// Data registers: BYPASS (1 bit), TEMPERATURE (8 bits), USER_WDR (WDR_WIDTH bits).
`timescale 1ns/1ps
module hbm_ieee1500_target_model #(
    parameter int          SYNC_STAGES = 2,
    parameter int          WDR_WIDTH   = 32,
    parameter logic [7:0]  OP_TEMP     = 8'h0F,
    parameter logic [7:0]  OP_USER     = 8'h10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wrck,
    input  logic                 wrst_n,
    input  logic                 shiftwr,
    input  logic                 capturewr,
    input  logic                 updatewr,
    input  logic                 selectwir,
    input  logic                 wsi,
    output logic [7:0]           wso,
    output logic [2:0]           temp,
    output logic                 cattrip,
    input  logic [6:0]           temp_code,
    input  logic                 cattrip_in,
    output logic [WDR_WIDTH-1:0] user_wdr,
    output logic                 user_upd
);

    // A synchroniser shallower than two flops is not safe; clamp it.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {SEL_BYPASS, SEL_TEMP, SEL_USER} wdr_sel_e;

    logic [STAGES-1:0][6:0] sync_q;
    logic [6:0]             bus_s;
    logic                   wrck_s, wrst_n_s, shift_s, capture_s, update_s, selwir_s, wsi_s;
    logic                   wrck_d;
    logic                   wrck_rise, wrck_fall;

    logic [11:0]            wir;
    logic [11:0]            wir_sr;
    logic [7:0]             temp_sr;
    logic [WDR_WIDTH-1:0]   user_sr;
    logic                   byp_sr;

    wdr_sel_e               wdr_sel;
    logic                   sel_lsb;
    logic [7:0]             wso_next;

    // Synchronise every bus input through STAGES flops.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {wrck, wrst_n, shiftwr, capturewr, updatewr, selectwir, wsi};
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign bus_s = sync_q[STAGES-1];
    assign {wrck_s, wrst_n_s, shift_s, capture_s, update_s, selwir_s, wsi_s} = bus_s;

    // One-clk delayed copy of synchronised wrck for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wrck_d <= 1'b0;
        else       wrck_d <= wrck_s;
    end

    assign wrck_rise =  wrck_s & ~wrck_d;
    assign wrck_fall = ~wrck_s &  wrck_d;

    // Decode the active data register and its serial output bit; unknown opcodes act as BYPASS.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        wdr_sel = SEL_BYPASS;
        if      (wir[7:0] == OP_TEMP) wdr_sel = SEL_TEMP;
        else if (wir[7:0] == OP_USER) wdr_sel = SEL_USER;

        sel_lsb = byp_sr;
        if (selwir_s) begin
            sel_lsb = wir_sr[0];
        end else begin
            case (wdr_sel)
                SEL_TEMP: sel_lsb = temp_sr[0];
                SEL_USER: sel_lsb = user_sr[0];
                default:  sel_lsb = byp_sr;
            endcase
        end

        wso_next = '0;
        if (wir[11:8] == 4'hF)  wso_next = {8{sel_lsb}};
        else if (!wir[11])      wso_next[wir[10:8]] = sel_lsb;
    end

    // Wrapper state machine: one prioritised action per wrck rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wir      <= '0;
            wir_sr   <= '0;
            temp_sr  <= '0;
            user_sr  <= '0;
            byp_sr   <= 1'b0;
            user_wdr <= '0;
            user_upd <= 1'b0;
        end else begin
            user_upd <= 1'b0;
            if (wrck_rise) begin
                if (!wrst_n_s) begin
                    wir     <= '0;
                    wir_sr  <= '0;
                    temp_sr <= '0;
                    user_sr <= '0;
                    byp_sr  <= 1'b0;
                end else if (capture_s) begin
                    if (selwir_s) begin
                        wir_sr <= 12'h001;
                    end else begin
                        case (wdr_sel)
                            SEL_TEMP: temp_sr <= {1'b1, temp_code};
                            SEL_USER: user_sr <= user_wdr;
                            default:  byp_sr  <= 1'b0;
                        endcase
                    end
                end else if (shift_s) begin
                    if (selwir_s) begin
                        wir_sr <= {wsi_s, wir_sr[11:1]};
                    end else begin
                        case (wdr_sel)
                            SEL_TEMP: temp_sr <= {wsi_s, temp_sr[7:1]};
                            SEL_USER: user_sr <= {wsi_s, user_sr[WDR_WIDTH-1:1]};
                            default:  byp_sr  <= wsi_s;
                        endcase
                    end
                end else if (update_s) begin
                    if (selwir_s) begin
                        wir <= wir_sr;
                    end else if (wdr_sel == SEL_USER) begin
                        user_wdr <= user_sr;
                        user_upd <= 1'b1;
                    end
                end
            end
        end
    end

    // Drive wso from the selected register LSB on each wrck fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          wso <= '0;
        else if (wrck_fall) wso <= wso_next;
    end

    // Coarse temperature: temp_code>>4 of a 7-bit code never exceeds 7, so no clamp is needed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) temp <= '0;
        else       temp <= temp_code[6:4];
    end

    // Sticky catastrophic-trip flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           cattrip <= 1'b0;
        else if (cattrip_in) cattrip <= 1'b1;
    end

endmodule
